// File: rtl/mips_pkg.sv
// Shared constants for the MIPS32 front end: PCSrc encodings, fetch FSM states and reset/trap vectors.
package mips_pkg;

  localparam logic [2:0] PCSRC_SEQ   = 3'b000;
  localparam logic [2:0] PCSRC_J     = 3'b001;
  localparam logic [2:0] PCSRC_JR    = 3'b010;
  localparam logic [2:0] PCSRC_ILLOP = 3'b011;
  localparam logic [2:0] PCSRC_XADR  = 3'b100;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VECTOR = 32'h8000_0004;
  localparam logic [31:0] XADR_VECTOR  = 32'h8000_0008;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_KILL = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Redirect arbitration for the fetch stage: traps beat taken branches, which beat jumps.
module if_pc_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = ILLOP_VECTOR,
  parameter logic [31:0] XADR_PC  = XADR_VECTOR
) (
  input  logic [2:0]  pc_src_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] jr_target_i,
  input  logic [31:0] branch_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  always_comb begin
    redirect_o = 1'b1;
    target_o   = '0;
    if (pc_src_i == PCSRC_ILLOP) begin
      target_o = word_align(ILLOP_PC);
    end else if (pc_src_i == PCSRC_XADR) begin
      target_o = word_align(XADR_PC);
    end else if (branch_i) begin
      target_o = word_align(branch_target_i);
    end else if (jump_i) begin
      target_o = (pc_src_i == PCSRC_JR) ? word_align(jr_target_i) : word_align(jump_target_i);
    end else begin
      redirect_o = 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage + IF/ID register: owns the PC, keeps one instruction-memory request in flight and
// parks a response that arrives during a stall in a one-entry hold buffer.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] ILLOP_PC = ILLOP_VECTOR,
  parameter logic [31:0] XADR_PC  = XADR_VECTOR,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        DataHazard,
  input  logic        ControlHazard_jump,
  input  logic        ControlHazard_branch,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  input  logic [31:0] BranchTarget,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] PC,
  output logic [1:0]  dbg_fetch_state
);

  // Memory handshake: a request transfers in a cycle where imem_req && imem_ready;
  // its single response is the next cycle with imem_rvalid, at least one cycle later.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, req_pc_q, req_pc_d;
  logic         buf_valid_q, buf_valid_d;
  logic [31:0]  buf_instr_q, buf_instr_d, buf_pc4_q, buf_pc4_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         redirect, advance, resp, issue;
  logic [31:0]  target, req_pc4;

  if_pc_sel #(.ILLOP_PC(ILLOP_PC), .XADR_PC(XADR_PC)) u_pc_sel (
    .pc_src_i       (PCSrc),
    .branch_i       (ControlHazard_branch),
    .jump_i         (ControlHazard_jump),
    .jump_target_i  (JumpTarget),
    .jr_target_i    (JrTarget),
    .branch_target_i(BranchTarget),
    .redirect_o     (redirect),
    .target_o       (target)
  );

  assign advance = !DataHazard;
  assign resp    = (state_q == FETCH_WAIT) && imem_rvalid;
  assign req_pc4 = req_pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    buf_valid_d  = buf_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    issue        = 1'b0;
    if (redirect) begin
      pc_d         = target;
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
      buf_valid_d  = 1'b0;
      // A response landing in the redirect cycle is the stale one, so nothing is left to kill.
      if (state_q == FETCH_WAIT) state_d = imem_rvalid ? FETCH_IDLE : FETCH_KILL;
      else if (state_q == FETCH_KILL && imem_rvalid) state_d = FETCH_IDLE;
    end else begin
      if (advance) begin
        if (buf_valid_q) begin
          ifid_instr_d = buf_instr_q;
          ifid_pc4_d   = buf_pc4_q;
          ifid_valid_d = 1'b1;
          buf_valid_d  = 1'b0;
        end else if (resp) begin
          ifid_instr_d = imem_rdata;
          ifid_pc4_d   = req_pc4;
          ifid_valid_d = 1'b1;
        end else begin
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
        end
      end else if (resp) begin
        buf_valid_d = 1'b1;
        buf_instr_d = imem_rdata;
        buf_pc4_d   = req_pc4;
      end
      case (state_q)
        FETCH_IDLE: issue = advance;
        FETCH_WAIT: if (imem_rvalid) begin
          issue   = advance;
          state_d = FETCH_IDLE;
        end
        FETCH_KILL: if (imem_rvalid) state_d = FETCH_IDLE;
        default:    state_d = FETCH_IDLE;
      endcase
      if (issue && imem_ready) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = FETCH_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= '0;
      buf_pc4_q    <= '0;
      ifid_instr_q <= NOP;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_req         = issue && !reset;
  assign imem_addr        = pc_q;
  assign PC               = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pc4_q;
  assign IFID_Valid       = ifid_valid_q;
  assign dbg_fetch_state  = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a variable-latency memory returning rdata=addr and a program-order
// scoreboard that expects consecutive word addresses, restarted at each redirect or reset.
module tb_if_fetch_stage;

  localparam logic [31:0] T_RESET = 32'h8000_0000;
  localparam logic [31:0] T_ILLOP = 32'h8000_0004;
  localparam logic [31:0] T_XADR  = 32'h8000_0008;
  localparam logic [31:0] T_NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        DataHazard, ControlHazard_jump, ControlHazard_branch;
  logic [31:0] JumpTarget, JrTarget, BranchTarget;
  logic        imem_ready, imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IFID_Instruction, IFID_PCPlus4, PC;
  logic        IFID_Valid;
  logic [1:0]  dbg_fetch_state;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .DataHazard(DataHazard),
    .ControlHazard_jump(ControlHazard_jump), .ControlHazard_branch(ControlHazard_branch),
    .JumpTarget(JumpTarget), .JrTarget(JrTarget), .BranchTarget(BranchTarget),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .PC(PC), .dbg_fetch_state(dbg_fetch_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // memory model state
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          ready_pct = 100, lat_min = 1, lat_max = 1;
  logic        acc_seen = 1'b0;
  logic [31:0] acc_addr = '0;

  // scoreboard: front entry is the address of the next instruction expected in IF/ID
  logic [31:0] exp_q[$];
  int          delivered = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void spec_redirect(output logic r, output logic [31:0] t);
    r = 1'b1;
    if (PCSrc == 3'b011) t = T_ILLOP;
    else if (PCSrc == 3'b100) t = T_XADR;
    else if (ControlHazard_branch) t = {BranchTarget[31:2], 2'b00};
    else if (ControlHazard_jump)
      t = (PCSrc == 3'b010) ? {JrTarget[31:2], 2'b00} : {JumpTarget[31:2], 2'b00};
    else begin
      r = 1'b0;
      t = '0;
    end
  endfunction

  // One clock: drive memory, sample at negedge, check the registered result 1 ns after posedge.
  task automatic cycle();
    logic redir, stall_c, was_reset, p_valid;
    logic [31:0] tgt, p_instr, p_pc4, p_pc, e;
    imem_ready  = ($urandom_range(99) < ready_pct);
    imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_addr : $urandom;
    spec_redirect(redir, tgt);
    @(negedge clk);
    p_instr = IFID_Instruction; p_pc4 = IFID_PCPlus4; p_valid = IFID_Valid; p_pc = PC;
    was_reset = reset;
    stall_c = DataHazard && !redir;
    acc_seen = 1'b0;
    if (reset) chk("req_in_reset", {31'b0, imem_req}, 32'd0);
    if (redir && !reset) chk("req_on_redirect", {31'b0, imem_req}, 32'd0);
    if (imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (imem_req && imem_ready && !reset) begin
      chk("one_outstanding", {31'b0, mem_pend}, 32'd0);
      chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
      acc_seen = 1'b1;
      acc_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    if (was_reset) begin
      chk("rst_valid", {31'b0, IFID_Valid}, 32'd0);
      chk("rst_instr", IFID_Instruction, T_NOP);
      chk("rst_pc4", IFID_PCPlus4, 32'd0);
      chk("rst_pc", PC, T_RESET);
      chk("rst_state_idle", {30'b0, dbg_fetch_state}, 32'd0);
      exp_q.delete();
      exp_q.push_back(T_RESET);
    end else if (redir) begin
      chk("redir_valid", {31'b0, IFID_Valid}, 32'd0);
      chk("redir_pc", PC, tgt);
      exp_q.delete();
      exp_q.push_back(tgt);
    end else if (stall_c) begin
      chk("stall_instr", IFID_Instruction, p_instr);
      chk("stall_pc4", IFID_PCPlus4, p_pc4);
      chk("stall_valid", {31'b0, IFID_Valid}, {31'b0, p_valid});
      chk("stall_pc", PC, p_pc);
    end else if (IFID_Valid) begin
      e = exp_q.pop_front();
      chk("order_pc4", IFID_PCPlus4, e + 32'd4);
      chk("order_instr", IFID_Instruction, e);
      exp_q.push_back(e + 32'd4);
      delivered++;
    end
    if (!IFID_Valid) chk("bubble_nop", IFID_Instruction, T_NOP);
  endtask

  task automatic wait_acc(input string tag, input logic [31:0] e);
    int n = 0;
    cycle();
    while (!acc_seen && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_seen"}, {31'b0, acc_seen}, 32'd1);
    if (acc_seen) chk(tag, acc_addr, e);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] e_pc4);
    int n = 0;
    cycle();
    while (!IFID_Valid && n < 30) begin
      cycle();
      n++;
    end
    chk({tag, "_seen"}, {31'b0, IFID_Valid}, 32'd1);
    if (IFID_Valid) chk(tag, IFID_PCPlus4, e_pc4);
  endtask

  task automatic clear_ctl();
    PCSrc = 3'b000; DataHazard = 1'b0;
    ControlHazard_jump = 1'b0; ControlHazard_branch = 1'b0;
  endtask

  initial begin
    int n, r, d0;
    reset = 1'b1; clear_ctl();
    JumpTarget = '0; JrTarget = '0; BranchTarget = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    #1;

    // 1: reset, then 1-cycle memory streams one instruction per cycle
    cycle();
    reset = 1'b0;
    cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t1_valid", {31'b0, IFID_Valid}, 32'd1);
      chk("t1_pc4", IFID_PCPlus4, T_RESET + 32'd4 + 32'(4 * i));
    end

    // 2: two-cycle stall with a response mid-stall, then drain
    DataHazard = 1'b1;
    cycle(); cycle();
    DataHazard = 1'b0;
    cycle();
    chk("t2_drain_valid", {31'b0, IFID_Valid}, 32'd1);
    for (int i = 0; i < 3; i++) cycle();

    // 3: taken branch while a 3-cycle request is outstanding
    lat_min = 3; lat_max = 3;
    n = 0;
    cycle();
    while (!acc_seen && n < 10) begin cycle(); n++; end
    BranchTarget = 32'h0000_0100; ControlHazard_branch = 1'b1;
    cycle();
    clear_ctl();
    wait_acc("t3_addr", 32'h0000_0100);
    wait_valid("t3_pc4", 32'h0000_0104);

    // 4: JR to a misaligned register value
    lat_min = 1; lat_max = 1;
    PCSrc = 3'b010; JrTarget = 32'h0000_2003; ControlHazard_jump = 1'b1;
    cycle();
    clear_ctl();
    wait_acc("t4_addr", 32'h0000_2000);
    wait_valid("t4_pc4", 32'h0000_2004);

    // 5: illegal-op trap wins over a data hazard
    PCSrc = 3'b011; DataHazard = 1'b1;
    cycle();
    clear_ctl();
    wait_acc("t5_addr", T_ILLOP);
    wait_valid("t5_pc4", T_ILLOP + 32'd4);

    // PC wrap at the top of the address space
    PCSrc = 3'b001; JumpTarget = 32'hFFFF_FFF8; ControlHazard_jump = 1'b1;
    cycle();
    clear_ctl();
    wait_valid("wrap_first", 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc4_top", IFID_PCPlus4, 32'h0000_0000);
    cycle();
    chk("wrap_pc4_zero", IFID_PCPlus4, 32'h0000_0004);

    // 6: reset while in WAIT; the stray response must be ignored
    lat_min = 2; lat_max = 2;
    n = 0;
    cycle();
    while (!acc_seen && n < 10) begin cycle(); n++; end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("t6_stray_rvalid", {31'b0, imem_rvalid}, 32'd1);
    chk("t6_stray_ignored", {31'b0, IFID_Valid}, 32'd0);
    chk("t6_req_addr", acc_addr, T_RESET);
    wait_valid("t6_pc4", T_RESET + 32'd4);

    // randomized traffic against the scoreboard
    ready_pct = 70; lat_min = 1; lat_max = 3;
    d0 = delivered;
    for (int i = 0; i < 600; i++) begin
      clear_ctl();
      DataHazard = ($urandom_range(99) < 20);
      r = $urandom_range(99);
      if (r < 3) begin
        ControlHazard_branch = 1'b1; BranchTarget = $urandom;
      end else if (r < 6) begin
        ControlHazard_jump = 1'b1;
        PCSrc = ($urandom_range(1) == 0) ? 3'b001 : 3'b010;
        JumpTarget = $urandom; JrTarget = $urandom;
      end else if (r == 6) begin
        PCSrc = ($urandom_range(1) == 0) ? 3'b011 : 3'b100;
      end
      cycle();
    end
    clear_ctl();
    for (int i = 0; i < 10; i++) cycle();
    chk("rand_progress", {31'b0, (delivered - d0) >= 30}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
